icache_nway_cwf: RTL and testbench

Parametrised N-way set-associative, read-only instruction cache that sits between the core fetch port and the instruction memory. It fetches lines critical-word-first with early restart, so the requested word returns before the rest of the line has been filled. Replacement is selectable between round-robin and tree pseudo-LRU. It also provides a flush input and saturating hit/miss counters for the compression study.

---
 rtl/icache_nway_cwf.sv | 217 +++++++++++++++++++++
 tb/tb_icache_nway_cwf.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway_cwf.sv
// N-way set-associative read-only instruction cache with critical-word-first
// line fill, early restart, round-robin or tree pseudo-LRU replacement.
//
// state          | meaning
// IDLE           | lookup on proc_addr; hits answered here, misses start a fill
// FILL           | requesting line words from w onward, wrapping; early restart on word w
// FILL_DONE_WAIT | one-cycle guard after a commit that had a flush pending
module icache_nway_cwf #(
    parameter int CACHE_SIZE  = 8192,
    parameter int NUM_WAYS    = 4,
    parameter int LINE_WORDS  = 4,
    parameter int REPL_POLICY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        proc_valid,
    output logic        proc_ready,
    input  logic [31:0] proc_addr,
    output logic [31:0] proc_rdata,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic [31:0] mem_req_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int SETS  = CACHE_SIZE / (4 * LINE_WORDS * NUM_WAYS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

    typedef logic [NUM_WAYS-2:0] plru_t;
    typedef enum logic [1:0] {IDLE, FILL, FILL_DONE_WAIT} state_t;

    // Walk root to leaf, pointing every node on the path away from the touched way.
    function automatic plru_t plru_touch(input plru_t bits, input logic [WAY_W-1:0] way);
        plru_t nb;
        int    node;
        nb   = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            nb[node] = ~way[WAY_W-1-l];
            node     = 2 * node + 1 + int'(way[WAY_W-1-l]);
        end
        return nb;
    endfunction

    logic [31:0]         data_q  [SETS][NUM_WAYS][LINE_WORDS];
    logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [WAY_W-1:0]    rr_q    [SETS];
    plru_t               plru_q  [SETS];

    state_t           state;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] f_idx;
    logic [OFF_W-1:0] f_word;
    logic [OFF_W-1:0] f_cnt;
    logic [WAY_W-1:0] f_way;
    logic             flush_pend;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;
    logic             unused_bits;

    assign a_tag       = proc_addr[31 -: TAG_W];
    assign a_idx       = proc_addr[2+OFF_W +: IDX_W];
    assign a_off       = proc_addr[2 +: OFF_W];
    assign unused_bits = ^proc_addr[1:0];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] plru_way;
    logic [WAY_W-1:0] victim;
    logic [31:0]      hit_word;
    logic [OFF_W-1:0] next_word;
    logic             fill_last;
    logic             clear_all;

    always_comb begin
        int node;
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        plru_way  = '0;
        node      = 0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[a_idx][w] && tag_q[a_idx][w] == a_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-numbered invalid way selected.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[a_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int l = 0; l < WAY_W; l++) begin
            plru_way[WAY_W-1-l] = plru_q[a_idx][node];
            node = 2 * node + 1 + int'(plru_q[a_idx][node]);
        end
        if (inv_found)
            victim = inv_way;
        else if (REPL_POLICY == 1)
            victim = plru_way;
        else
            victim = rr_q[a_idx];
        hit_word = data_q[a_idx][hit_way][a_off];
    end

    assign next_word = f_word + OFF_W'(1);
    assign fill_last = (state == FILL) && mem_req_ready && (f_cnt == LAST_CNT);
    assign clear_all = (state == IDLE && flush) || (state == FILL_DONE_WAIT);

    // Line storage carries no reset; the valid bits alone decide what is a hit.
    always_ff @(posedge clk) begin
        if (!reset && state == FILL && mem_req_ready) begin
            data_q[f_idx][f_way][f_word] <= mem_req_rdata;
            if (f_cnt == LAST_CNT)
                tag_q[f_idx][f_way] <= f_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            proc_ready    <= 1'b0;
            proc_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            f_tag         <= '0;
            f_idx         <= '0;
            f_word        <= '0;
            f_cnt         <= '0;
            f_way         <= '0;
            flush_pend    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            proc_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (proc_valid && !proc_ready) begin
                        if (hit) begin
                            proc_rdata <= hit_word;
                            proc_ready <= 1'b1;
                            if (hit_count != '1)
                                hit_count <= hit_count + 32'd1;
                            if (REPL_POLICY == 1)
                                plru_q[a_idx] <= plru_touch(plru_q[a_idx], hit_way);
                        end else begin
                            f_tag         <= a_tag;
                            f_idx         <= a_idx;
                            f_word        <= a_off;
                            f_cnt         <= '0;
                            f_way         <= victim;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {a_tag, a_idx, a_off, 2'b00};
                            if (miss_count != '1)
                                miss_count <= miss_count + 32'd1;
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (mem_req_ready) begin
                        if (f_cnt == '0) begin
                            proc_rdata <= mem_req_rdata;
                            proc_ready <= 1'b1;
                        end
                        f_cnt        <= f_cnt + OFF_W'(1);
                        f_word       <= next_word;
                        mem_req_addr <= {f_tag, f_idx, next_word, 2'b00};
                    end
                    if (fill_last) begin
                        mem_req_valid        <= 1'b0;
                        valid_q[f_idx][f_way] <= 1'b1;
                        rr_q[f_idx]          <= rr_q[f_idx] + WAY_W'(1);
                        plru_q[f_idx]        <= plru_touch(plru_q[f_idx], f_way);
                        state <= (flush_pend || flush) ? FILL_DONE_WAIT : IDLE;
                    end
                end
                FILL_DONE_WAIT: begin
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Flush overrides any hit-time replacement update in the same cycle.
            if (clear_all) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                    plru_q[s]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_nway_cwf.sv
// Directed bench for icache_nway_cwf: one round-robin and one PLRU instance,
// checked every cycle against a line-level cache model kept in the bench.
module tb_icache_nway_cwf;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        proc_valid = '0;
    logic [1:0]        flush = '0;
    logic [1:0]        mem_req_ready = '0;
    logic [1:0][31:0]  proc_addr = '0;
    logic [1:0]        proc_ready;
    logic [1:0]        mem_req_valid;
    logic [1:0][31:0]  proc_rdata;
    logic [1:0][31:0]  mem_req_addr;
    logic [1:0][31:0]  mem_req_rdata;
    logic [1:0][31:0]  hit_count;
    logic [1:0][31:0]  miss_count;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        icache_nway_cwf #(
            .CACHE_SIZE(8192), .NUM_WAYS(4), .LINE_WORDS(4), .REPL_POLICY(g)
        ) dut (
            .clk(clk), .reset(reset),
            .proc_valid(proc_valid[g]), .proc_ready(proc_ready[g]),
            .proc_addr(proc_addr[g]), .proc_rdata(proc_rdata[g]),
            .flush(flush[g]),
            .mem_req_valid(mem_req_valid[g]), .mem_req_ready(mem_req_ready[g]),
            .mem_req_addr(mem_req_addr[g]), .mem_req_rdata(mem_req_rdata[g]),
            .hit_count(hit_count[g]), .miss_count(miss_count[g])
        );
        assign mem_req_rdata[g] = mem_req_addr[g] ^ PAT;
    end

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cur = 0;
    bit          chk_en = 0;
    bit          exp_ready = 0;
    bit          exp_mvalid = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_maddr = '0;
    logic [31:0] last_rdata = '0;
    logic [31:0] mlog[$];

    // Model: 128 sets x 4 ways, tags only; data is always address ^ PAT.
    bit m_vld  [2][128][4];
    int m_tag  [2][128][4];
    int m_rr   [2][128];
    bit m_plru [2][128][3];
    int exp_hits [2];
    int exp_misses [2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic int m_set(logic [31:0] a);
        return int'(a[10:4]);
    endfunction

    function automatic int m_tagof(logic [31:0] a);
        return int'(a[31:11]);
    endfunction

    function automatic bit m_lookup(int d, logic [31:0] a, output int way);
        way = 0;
        for (int w = 0; w < 4; w++)
            if (m_vld[d][m_set(a)][w] && m_tag[d][m_set(a)][w] == m_tagof(a)) begin
                way = w;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    // Bit 0 chooses between way pairs {0,1}/{2,3}; bits 1/2 inside each pair; 1 = take right.
    function automatic void m_touch(int d, int s, int w);
        m_plru[d][s][0] = (w < 2);
        if (w < 2) m_plru[d][s][1] = (w == 0);
        else       m_plru[d][s][2] = (w == 2);
    endfunction

    function automatic int m_victim(int d, int s);
        for (int w = 0; w < 4; w++)
            if (!m_vld[d][s][w]) return w;
        if (d == 0) return m_rr[d][s];
        if (!m_plru[d][s][0]) return m_plru[d][s][1] ? 1 : 0;
        return m_plru[d][s][2] ? 3 : 2;
    endfunction

    function automatic void m_fill(int d, logic [31:0] a);
        int s = m_set(a);
        int v = m_victim(d, s);
        m_vld[d][s][v] = 1'b1;
        m_tag[d][s][v] = m_tagof(a);
        m_rr[d][s] = (m_rr[d][s] + 1) % 4;
        m_touch(d, s, v);
    endfunction

    function automatic void m_flush(int d);
        for (int s = 0; s < 128; s++) begin
            m_rr[d][s] = 0;
            for (int w = 0; w < 4; w++) m_vld[d][s][w] = 1'b0;
            for (int n = 0; n < 3; n++) m_plru[d][s][n] = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_flush(d);
            exp_hits[d] = 0;
            exp_misses[d] = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("proc_ready", 32'(proc_ready[cur]), 32'(exp_ready));
            if (exp_ready) check("proc_rdata", proc_rdata[cur], exp_rdata);
            check("mem_req_valid", 32'(mem_req_valid[cur]), 32'(exp_mvalid));
            if (exp_mvalid) check("mem_req_addr", mem_req_addr[cur], exp_maddr);
            check("hit_count", hit_count[cur], 32'(exp_hits[cur]));
            check("miss_count", miss_count[cur], 32'(exp_misses[cur]));
        end
        if (proc_ready[cur]) last_rdata = proc_rdata[cur];
        if (mem_req_valid[cur] && mem_req_ready[cur]) mlog.push_back(mem_req_addr[cur]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch on DUT cur; ws wait cycles per word; flush_at/reset_at name the
    // word slot (0..3) at which a flush pulse or a reset is injected, -1 for none.
    task automatic fetch(input logic [31:0] a, input int ws, input int flush_at, input int reset_at);
        int          d = cur;
        int          way;
        int          w = int'(a[3:2]);
        bit          flushp = 0;
        bit          aborted = 0;
        logic [31:0] base = {a[31:4], 4'h0};
        mlog.delete();
        proc_valid[d] = 1'b1;
        proc_addr[d] = a;
        if (m_lookup(d, a, way)) begin
            if (flush_at == 0) flush[d] = 1'b1;
            tick();
            flush[d] = 1'b0;
            proc_valid[d] = 1'b0;
            exp_hits[d]++;
            exp_ready = 1;
            exp_rdata = {a[31:2], 2'b00} ^ PAT;
            if (d == 1) m_touch(d, m_set(a), way);
            if (flush_at == 0) m_flush(d);
            tick();
            exp_ready = 0;
        end else begin
            tick();
            exp_misses[d]++;
            exp_mvalid = 1;
            exp_maddr = base | 32'(w << 2);
            for (int i = 0; i < 4; i++) begin
                if (i == reset_at) begin
                    reset = 1'b1;
                    mem_req_ready[d] = 1'b0;
                    proc_valid[d] = 1'b0;
                    tick();
                    reset = 1'b0;
                    m_reset();
                    exp_ready = 0;
                    exp_mvalid = 0;
                    aborted = 1;
                    break;
                end
                repeat (ws) begin
                    tick();
                    exp_ready = 0;
                end
                mem_req_ready[d] = 1'b1;
                if (i == flush_at) begin
                    flush[d] = 1'b1;
                    flushp = 1;
                end
                tick();
                mem_req_ready[d] = 1'b0;
                flush[d] = 1'b0;
                exp_ready = (i == 0);
                if (i == 0) begin
                    exp_rdata = exp_maddr ^ PAT;
                    proc_valid[d] = 1'b0;
                end
                if (i < 3) exp_maddr = base | 32'(((w + i + 1) % 4) << 2);
                else       exp_mvalid = 0;
            end
            if (!aborted) begin
                m_fill(d, a);
                if (flushp) begin
                    tick();
                    m_flush(d);
                end
            end
        end
    endtask

    task automatic flush_idle();
        flush[cur] = 1'b1;
        tick();
        flush[cur] = 1'b0;
        m_flush(cur);
    endtask

    int h0, m0;

    initial begin
        m_reset();
        repeat (2) tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("rst_proc_ready", 32'(proc_ready[d]), 32'd0);
            check("rst_proc_rdata", proc_rdata[d], 32'd0);
            check("rst_mem_req_valid", 32'(mem_req_valid[d]), 32'd0);
            check("rst_mem_req_addr", mem_req_addr[d], 32'd0);
            check("rst_hit_count", hit_count[d], 32'd0);
            check("rst_miss_count", miss_count[d], 32'd0);
        end
        chk_en = 1;

        for (int d = 0; d < 2; d++) begin
            cur = d;
            fetch(32'h0000_1008, 0, -1, -1);
            check("cwf_n", 32'(mlog.size()), 32'd4);
            check("cwf_a0", mlog[0], 32'h0000_1008);
            check("cwf_a1", mlog[1], 32'h0000_100C);
            check("cwf_a2", mlog[2], 32'h0000_1000);
            check("cwf_a3", mlog[3], 32'h0000_1004);
            check("cwf_word", last_rdata, 32'hA5A5_B5AD);
            check("cwf_miss", miss_count[d], 32'd1);

            fetch(32'h0000_1000, 0, -1, -1);
            check("hit_word", last_rdata, 32'hA5A5_B5A5);
            check("hit_nomem", 32'(mlog.size()), 32'd0);
            check("hit_cnt", hit_count[d], 32'd1);

            flush_idle();
            fetch(32'h0000_0000, 0, -1, -1);
            fetch(32'h0000_2000, 0, -1, -1);
            fetch(32'h0000_4000, 0, -1, -1);
            fetch(32'h0000_6000, 0, -1, -1);
            if (d == 1) begin
                fetch(32'h0000_0000, 0, -1, -1);
                fetch(32'h0000_6000, 0, -1, -1);
            end
            h0 = int'(hit_count[d]);
            m0 = int'(miss_count[d]);
            fetch(32'h0000_8000, 0, -1, -1);
            fetch(d == 0 ? 32'h0000_2000 : 32'h0000_0000, 0, -1, -1);
            fetch(32'h0000_4000, 0, -1, -1);
            fetch(32'h0000_6000, 0, -1, -1);
            fetch(32'h0000_8000, 0, -1, -1);
            fetch(d == 0 ? 32'h0000_0000 : 32'h0000_2000, 0, -1, -1);
            check("evict_hits", hit_count[d] - 32'(h0), 32'd4);
            check("evict_misses", miss_count[d] - 32'(m0), 32'd2);

            fetch(32'h0000_3004, 0, 1, -1);
            m0 = int'(miss_count[d]);
            fetch(32'h0000_3004, 0, -1, -1);
            check("flush_mid_fill", miss_count[d] - 32'(m0), 32'd1);

            fetch(32'h0000_5008, 0, 3, -1);
            check("flush_last_word", last_rdata, 32'h0000_5008 ^ PAT);
            m0 = int'(miss_count[d]);
            fetch(32'h0000_5008, 0, -1, -1);
            check("flush_last_refill", miss_count[d] - 32'(m0), 32'd1);

            h0 = int'(hit_count[d]);
            fetch(32'h0000_5008, 0, 0, -1);
            check("flush_idle_hit", hit_count[d] - 32'(h0), 32'd1);
            m0 = int'(miss_count[d]);
            fetch(32'h0000_5008, 0, -1, -1);
            check("flush_idle_miss", miss_count[d] - 32'(m0), 32'd1);

            fetch(32'h0000_7FFC, 7, -1, -1);
            check("slow_word", last_rdata, 32'hA5A5_DA59);
            check("slow_a1", mlog[1], 32'h0000_7FF0);
        end

        cur = 0;
        fetch(32'h0000_9000, 0, -1, 2);
        check("rst_fill_valid", 32'(mem_req_valid[0]), 32'd0);
        fetch(32'h0000_9000, 0, -1, -1);
        check("rst_fill_remiss", miss_count[0], 32'd1);
        check("rst_fill_hits", hit_count[0], 32'd0);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
